// File: rtl/btn_event_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_pkg
// Shared definitions for the button event detector. It holds the FSM state
// encoding, the default timing parameters, and a helper that sizes the
// hold/repeat counters.
// -----------------------------------------------------------------------------
package btn_event_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } state_e;

  // 2^20 cycles at 50 MHz gives a tick of about 21 ms.
  localparam int unsigned DEF_TICK_BITS    = 20;
  localparam int unsigned DEF_LONG_TICKS   = 50;
  localparam int unsigned DEF_REPEAT_TICKS = 10;

  // Returns the width needed to count 0 .. terminal-1.
  // It never returns less than 1 bit, so a terminal of 1 still gets a counter.
  function automatic int unsigned cnt_width(input int unsigned terminal);
    return (terminal > 1) ? $clog2(terminal) : 1;
  endfunction

endpackage

// File: rtl/btn_event_tick_gen.sv
// -----------------------------------------------------------------------------
// tick_gen
// Free-running timebase. A TICK_BITS-wide counter advances by one every clock
// and wraps around. tick is high for the single cycle in which the counter
// reads zero. The counter is never restarted by button activity.
//
// Ports
//   clk    in   system clock, rising edge
//   reset  in   asynchronous reset, active low
//   tick   out  high for one cycle every 2^TICK_BITS clocks
// -----------------------------------------------------------------------------
module tick_gen
  import btn_event_pkg::*;
#(
  parameter int unsigned TICK_BITS = DEF_TICK_BITS
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  logic [TICK_BITS-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + TICK_BITS'(1);
    end
  end

  assign tick = (cnt_q == '0);

endmodule

// File: rtl/btn_event.sv
// -----------------------------------------------------------------------------
// btn_event
// Turns a debounced button level into discrete events:
//   - press and release pulses,
//   - a long-press pulse after LONG_TICKS timebase ticks of continuous hold,
//   - auto-repeat pulses every REPEAT_TICKS ticks while the button stays held,
//   - a held_long level,
//   - an 8-bit wrapping press counter.
// Every output is registered. Each pulse appears one clock after the edge
// that triggers it.
//
// Ports
//   clk           in   system clock, rising edge
//   reset         in   asynchronous reset, active low
//   db            in   debounced button level, 1 = pressed, synchronous to clk
//   press_tick    out  one-cycle pulse on press
//   release_tick  out  one-cycle pulse on release
//   long_tick     out  one-cycle pulse when the hold reaches LONG_TICKS
//   repeat_tick   out  one-cycle pulse every REPEAT_TICKS while long-held
//   held_long     out  level, high while in the long-press state
//   press_cnt     out  [7:0] presses since reset, wraps 255 -> 0
// -----------------------------------------------------------------------------
module btn_event
  import btn_event_pkg::*;
#(
  parameter int unsigned TICK_BITS    = DEF_TICK_BITS,
  parameter int unsigned LONG_TICKS   = DEF_LONG_TICKS,
  parameter int unsigned REPEAT_TICKS = DEF_REPEAT_TICKS
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       db,
  output logic       press_tick,
  output logic       release_tick,
  output logic       long_tick,
  output logic       repeat_tick,
  output logic       held_long,
  output logic [7:0] press_cnt
);

  localparam int unsigned HOLD_W = cnt_width(LONG_TICKS);
  localparam int unsigned REP_W  = cnt_width(REPEAT_TICKS);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 1);

  state_e            state_q;
  logic              db_q;
  logic [HOLD_W-1:0] hold_cnt_q;
  logic [REP_W-1:0]  rep_cnt_q;
  logic              press_tick_q;
  logic              release_tick_q;
  logic              long_tick_q;
  logic              repeat_tick_q;
  logic              held_long_q;
  logic [7:0]        press_cnt_q;

  logic tb_tick;
  logic rise;
  logic fall;

  tick_gen #(
    .TICK_BITS(TICK_BITS)
  ) u_tick_gen (
    .clk  (clk),
    .reset(reset),
    .tick (tb_tick)
  );

  // db_q clears on reset. If the button is held through reset release, this
  // produces a rise on the first cycle, so that press is still reported.
  assign rise = db & ~db_q;
  assign fall = ~db & db_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      db_q           <= 1'b0;
      hold_cnt_q     <= '0;
      rep_cnt_q      <= '0;
      press_tick_q   <= 1'b0;
      release_tick_q <= 1'b0;
      long_tick_q    <= 1'b0;
      repeat_tick_q  <= 1'b0;
      held_long_q    <= 1'b0;
      press_cnt_q    <= '0;
    end else begin
      db_q           <= db;
      press_tick_q   <= 1'b0;
      release_tick_q <= 1'b0;
      long_tick_q    <= 1'b0;
      repeat_tick_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          held_long_q <= 1'b0;
          // A tick in the rise cycle itself is not counted toward the hold.
          if (rise) begin
            state_q      <= ST_PRESSED;
            hold_cnt_q   <= '0;
            rep_cnt_q    <= '0;
            press_tick_q <= 1'b1;
            press_cnt_q  <= press_cnt_q + 8'd1;
          end
        end

        ST_PRESSED: begin
          // Release takes priority over a threshold tick in the same cycle.
          if (fall) begin
            state_q        <= ST_IDLE;
            release_tick_q <= 1'b1;
            hold_cnt_q     <= '0;
            rep_cnt_q      <= '0;
          end else if (tb_tick) begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_q     <= ST_LONG;
              long_tick_q <= 1'b1;
              held_long_q <= 1'b1;
              rep_cnt_q   <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + HOLD_W'(1);
            end
          end
        end

        ST_LONG: begin
          if (fall) begin
            state_q        <= ST_IDLE;
            release_tick_q <= 1'b1;
            held_long_q    <= 1'b0;
            hold_cnt_q     <= '0;
            rep_cnt_q      <= '0;
          end else if (tb_tick) begin
            if (rep_cnt_q == REP_LAST) begin
              repeat_tick_q <= 1'b1;
              rep_cnt_q     <= '0;
            end else begin
              rep_cnt_q <= rep_cnt_q + REP_W'(1);
            end
          end
        end

        // Unused encoding: go back to idle quietly, without emitting any pulse.
        default: begin
          state_q     <= ST_IDLE;
          hold_cnt_q  <= '0;
          rep_cnt_q   <= '0;
          held_long_q <= 1'b0;
        end
      endcase
    end
  end

  assign press_tick   = press_tick_q;
  assign release_tick = release_tick_q;
  assign long_tick    = long_tick_q;
  assign repeat_tick  = repeat_tick_q;
  assign held_long    = held_long_q;
  assign press_cnt    = press_cnt_q;

endmodule

// File: tb/tb_btn_event.sv
// -----------------------------------------------------------------------------
// tb_btn_event
// Self-checking bench for btn_event with a short timebase: a tick every 16
// clocks, long press after 3 ticks, auto-repeat every 2 ticks.
// The reference model works from the press history alone. It counts the
// timebase ticks elapsed since the rise cycle (timebase ticks fall on
// multiples of 16 cycles after reset release), and from that count it derives
// the long-press, repeat and held_long expectations.
// -----------------------------------------------------------------------------
module tb_btn_event;

  localparam int PER = 16;
  localparam int LT  = 3;
  localparam int RT  = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       db;
  logic       press_tick;
  logic       release_tick;
  logic       long_tick;
  logic       repeat_tick;
  logic       held_long;
  logic [7:0] press_cnt;

  btn_event #(
    .TICK_BITS   (4),
    .LONG_TICKS  (LT),
    .REPEAT_TICKS(RT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .db          (db),
    .press_tick  (press_tick),
    .release_tick(release_tick),
    .long_tick   (long_tick),
    .repeat_tick (repeat_tick),
    .held_long   (held_long),
    .press_cnt   (press_cnt)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model state: k is the clock edge index since reset release.
  int         k;
  logic       m_prev;
  int         m_rise_k;
  logic [7:0] m_cnt;

  // Observed pulse totals.
  int n_press;
  int n_rel;
  int n_long;
  int n_rep;
  int saw_held;

  typedef struct {
    int   phase;     // rise edge index modulo 16
    int   hold;      // cycles db stays high, starting with the rise edge
    int   exp_long;
    int   exp_rep;
    logic exp_held;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, k);
    end
  endtask

  function automatic logic [31:0] outs();
    return {19'd0, press_tick, release_tick, long_tick, repeat_tick, held_long, press_cnt};
  endfunction

  // Drive db for one clock edge, then compare every output against the model.
  task automatic step(input logic d);
    logic r_e, f_e, hld, tk, e_long, e_rep, e_held;
    int   n;
    db = d;
    @(posedge clk);
    r_e = d & ~m_prev;
    f_e = ~d & m_prev;
    hld = d & m_prev;
    if (r_e) begin
      m_rise_k = k;
      m_cnt    = m_cnt + 8'd1;
    end
    n      = k / PER - m_rise_k / PER;   // ticks in (rise edge, this edge]
    tk     = (k % PER == 0);
    e_long = hld && tk && (n == LT);
    e_rep  = hld && tk && (n > LT) && ((n - LT) % RT == 0);
    e_held = hld && (n >= LT);
    m_prev = d;
    #1;
    chk("outputs{press,release,long,repeat,held_long,press_cnt}", outs(),
        {19'd0, r_e, f_e, e_long, e_rep, e_held, m_cnt});
    if (press_tick === 1'b1)   n_press++;
    if (release_tick === 1'b1) n_rel++;
    if (long_tick === 1'b1)    n_long++;
    if (repeat_tick === 1'b1)  n_rep++;
    if (held_long === 1'b1)    saw_held = 1;
    k++;
  endtask

  // Called #1 after a rising edge. Asserts reset between edges, then releases
  // it on a falling edge, so the next rising edge is index 0.
  task automatic apply_reset(input int cycles);
    #3 reset = 1'b0;
    #1 chk("async_reset_outputs_zero", outs(), 32'd0);
    repeat (cycles) @(posedge clk);
    #1 chk("reset_held_outputs_zero", outs(), 32'd0);
    @(negedge clk);
    reset    = 1'b1;
    k        = 0;
    m_prev   = 1'b0;
    m_rise_k = 0;
    m_cnt    = 8'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p_snap, r_snap, l_snap, rp_snap, lvl, len;
    logic [7:0] c_snap;

    vecs[0] = '{phase: 5,  hold: 20,  exp_long: 0, exp_rep: 0, exp_held: 1'b0}; // short press
    vecs[1] = '{phase: 0,  hold: 48,  exp_long: 0, exp_rep: 0, exp_held: 1'b0}; // fall on 3rd tick
    vecs[2] = '{phase: 0,  hold: 49,  exp_long: 1, exp_rep: 0, exp_held: 1'b1}; // just long
    vecs[3] = '{phase: 1,  hold: 100, exp_long: 1, exp_rep: 1, exp_held: 1'b1};
    vecs[4] = '{phase: 15, hold: 130, exp_long: 1, exp_rep: 3, exp_held: 1'b1};
    vecs[5] = '{phase: 8,  hold: 64,  exp_long: 1, exp_rep: 0, exp_held: 1'b1};

    n_press = 0; n_rel = 0; n_long = 0; n_rep = 0; saw_held = 0;
    k = 0; m_prev = 1'b0; m_rise_k = 0; m_cnt = 8'd0;

    // Power-up reset.
    reset = 1'b0;
    db    = 1'b0;
    #1 chk("reset_state", outs(), 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    step(1'b0);
    step(1'b0);

    // Table-driven presses.
    for (int i = 0; i < 6; i++) begin
      step(1'b0);
      while (k % PER != vecs[i].phase) step(1'b0);
      p_snap = n_press; r_snap = n_rel; l_snap = n_long; rp_snap = n_rep;
      c_snap = press_cnt;
      saw_held = 0;
      repeat (vecs[i].hold) step(1'b1);
      repeat (3) step(1'b0);
      chk($sformatf("vec%0d_press_pulses", i),   n_press - p_snap, 1);
      chk($sformatf("vec%0d_release_pulses", i), n_rel - r_snap, 1);
      chk($sformatf("vec%0d_long_pulses", i),    n_long - l_snap, vecs[i].exp_long);
      chk($sformatf("vec%0d_repeat_pulses", i),  n_rep - rp_snap, vecs[i].exp_rep);
      chk($sformatf("vec%0d_held_long_seen", i), saw_held, {31'd0, vecs[i].exp_held});
      chk($sformatf("vec%0d_press_cnt", i),      press_cnt, c_snap + 8'd1);
      chk($sformatf("vec%0d_idle_after", i),     held_long, 1'b0);
    end

    // 256 short presses from a fresh reset: the counter wraps back to zero.
    apply_reset(2);
    step(1'b0);
    p_snap = n_press;
    for (int i = 0; i < 256; i++) begin
      step(1'b1);
      step(1'b1);
      step(1'b0);
      step(1'b0);
    end
    chk("wrap_press_pulses", n_press - p_snap, 256);
    chk("wrap_press_cnt", press_cnt, 8'd0);

    // Reset during a long hold, with db still high at release.
    step(1'b0);
    step(1'b1);
    repeat (60) step(1'b1);
    chk("held_long_before_reset", held_long, 1'b1);
    r_snap = n_rel;
    apply_reset(3);
    step(1'b1);
    chk("press_after_reset_cnt", press_cnt, 8'd1);
    chk("no_release_through_reset", n_rel, r_snap);
    repeat (5) step(1'b1);
    step(1'b0);
    chk("release_after_reset_press", n_rel, r_snap + 1);

    // Random press/release runs.
    for (int i = 0; i < 40; i++) begin
      lvl = $urandom_range(0, 1);
      len = $urandom_range(1, 70);
      repeat (len) step(lvl[0]);
    end
    step(1'b0);
    step(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
